// File: rtl/mac_datapath.sv
// Multiply-accumulate datapath for one dot product, with a one-entry result buffer and a sticky overflow flag.
// Optional feature: define MAC_SIGNED_EN for two's-complement arithmetic (default build is unsigned).
module mac_datapath #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ACC_W = 2*WIDTH + $clog2(SIZE) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    load_en,
   input  logic                    mult_en,
   input  logic                    acc_en,
   input  logic [SIZE-1:0]         memsel,
   input  logic                    done,
   input  logic [SIZE*WIDTH-1:0]   a_row,
   input  logic [SIZE*WIDTH-1:0]   b_col,
   output logic [ACC_W-1:0]        result,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [$clog2(SIZE):0]   acc_count,
   output logic                    ovf_err,
   input  logic                    err_clr
);

   localparam int unsigned PROD_W = 2*WIDTH;
   localparam int unsigned CNT_W  = $clog2(SIZE) + 1;
   localparam int unsigned EXT_W  = ACC_W - PROD_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic [PROD_W-1:0]   prod_reg;
   logic [ACC_W-1:0]    acc;

   logic [WIDTH-1:0]    a_sel_c;
   logic [WIDTH-1:0]    b_sel_c;
   logic [PROD_W-1:0]   prod_nxt_c;
   logic [ACC_W-1:0]    prod_ext_c;
   logic                run_c;
   logic                load_res_c;
   logic                drop_c;

   // Element select: highest set memsel bit wins; an all-zero select yields zero operands.
   always_comb begin
      a_sel_c = '0;
      b_sel_c = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         if (memsel[i]) begin
            a_sel_c = a_row[i*WIDTH +: WIDTH];
            b_sel_c = b_col[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef MAC_SIGNED_EN
   assign prod_nxt_c = PROD_W'($signed(a_reg)) * PROD_W'($signed(b_reg));
   assign prod_ext_c = {{EXT_W{prod_reg[PROD_W-1]}}, prod_reg};
`else
   assign prod_nxt_c = PROD_W'(a_reg) * PROD_W'(b_reg);
   assign prod_ext_c = {{EXT_W{1'b0}}, prod_reg};
`endif

   // Next state plus result-buffer decisions; start overrides done's return to IDLE.
   always_comb begin
      state_d    = state_q;
      run_c      = (state_q == ST_RUN);
      load_res_c = 1'b0;
      drop_c     = 1'b0;
      if (run_c && done) begin
         if (!result_valid || result_ready) begin
            load_res_c = 1'b1;
         end else begin
            drop_c = 1'b1;
         end
         state_d = ST_IDLE;
      end
      if (start) begin
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand, product and accumulator registers; enables act independently on pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         prod_reg  <= '0;
         acc       <= '0;
         acc_count <= '0;
      end else if (start) begin
         a_reg     <= '0;
         b_reg     <= '0;
         prod_reg  <= '0;
         acc       <= '0;
         acc_count <= '0;
      end else if (run_c) begin
         if (load_en) begin
            a_reg <= a_sel_c;
            b_reg <= b_sel_c;
         end
         if (mult_en) begin
            prod_reg <= prod_nxt_c;
         end
         if (acc_en) begin
            acc <= acc + prod_ext_c;
            if (acc_count != CNT_W'(SIZE)) begin
               acc_count <= acc_count + CNT_W'(1);
            end
         end
      end
   end

   // One-entry output buffer; a load and a consume in the same cycle keep it full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else if (load_res_c) begin
         result       <= acc;
         result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
         result_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_err <= 1'b0;
      end else if (drop_c) begin
         ovf_err <= 1'b1;
      end else if (err_clr) begin
         ovf_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_datapath.sv
// Self-checking bench for mac_datapath: directed scenarios plus randomized dot products against an arithmetic model.
module tb_mac_datapath;

   localparam int unsigned SIZE  = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned ACC_W = 2*WIDTH + $clog2(SIZE) + 1;
   localparam int unsigned CNT_W = $clog2(SIZE) + 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start, load_en, mult_en, acc_en, done;
   logic                  result_ready, err_clr;
   logic [SIZE-1:0]       memsel;
   logic [SIZE*WIDTH-1:0] a_row, b_col;
   logic [ACC_W-1:0]      result;
   logic                  result_valid, ovf_err;
   logic [CNT_W-1:0]      acc_count;

   int checks = 0;
   int errors = 0;

   mac_datapath #(.SIZE(SIZE), .WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en), .mult_en(mult_en),
      .acc_en(acc_en), .memsel(memsel), .done(done), .a_row(a_row), .b_col(b_col),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .acc_count(acc_count), .ovf_err(ovf_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Reference dot product of the first n element pairs, wrapped to ACC_W bits.
   function automatic logic [ACC_W-1:0] model_dot(input logic [SIZE*WIDTH-1:0] a,
                                                  input logic [SIZE*WIDTH-1:0] b, input int n);
      longint sum;
      logic [WIDTH-1:0] ea, eb;
      sum = 0;
      for (int i = 0; i < n; i++) begin
         ea = a[i*WIDTH +: WIDTH];
         eb = b[i*WIDTH +: WIDTH];
`ifdef MAC_SIGNED_EN
         sum += longint'($signed(ea)) * longint'($signed(eb));
`else
         sum += longint'(ea) * longint'(eb);
`endif
      end
      return ACC_W'(sum);
   endfunction

   function automatic logic [SIZE-1:0] therm(input int k);
      logic [SIZE-1:0] m;
      m = '0;
      for (int i = 0; i <= k && i < SIZE; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [SIZE*WIDTH-1:0] rand_vec();
      logic [SIZE*WIDTH-1:0] v;
      for (int i = 0; i < SIZE; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom());
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; load_en = 0; mult_en = 0; acc_en = 0; done = 0;
      result_ready = 0; err_clr = 0; memsel = '0; a_row = '0; b_col = '0;
   endtask

   task automatic mac_step(input int k);
      memsel = therm(k);
      load_en = 1; cyc(); load_en = 0;
      mult_en = 1; cyc(); mult_en = 0;
      acc_en  = 1; cyc(); acc_en  = 0;
   endtask

   task automatic run_dot(input logic [SIZE*WIDTH-1:0] a, input logic [SIZE*WIDTH-1:0] b,
                          input int n, input logic rdy_done);
      a_row = a; b_col = b;
      start = 1; cyc(); start = 0;
      for (int k = 0; k < n; k++) mac_step(k);
      done = 1; result_ready = rdy_done; cyc();
      done = 0; result_ready = 0;
   endtask

   task automatic consume();
      result_ready = 1; cyc(); result_ready = 0;
   endtask

   task automatic test_reset();
      reset = 0;
      clear_inputs();
      cyc(); cyc();
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0h want 0", result); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", result_valid); end
      checks++; if (acc_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", acc_count); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf_err); end
      reset = 1;
      cyc();
      acc_en = 1; done = 1; cyc(); acc_en = 0; done = 0;
      checks++; if (acc_count !== '0) begin errors++; $display("FAIL idle_acc_ignored: got %0d want 0", acc_count); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: got %0b want 0", result_valid); end
   endtask

   task automatic test_unsigned_dot();
      a_row = {8'd4, 8'd3, 8'd2, 8'd1};
      b_col = {8'd8, 8'd7, 8'd6, 8'd5};
      start = 1; cyc(); start = 0;
      for (int k = 0; k < SIZE; k++) mac_step(k);
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL dot_latency_valid: got %0b want 0", result_valid); end
      done = 1; cyc(); done = 0;
      checks++; if (result !== ACC_W'(70)) begin errors++; $display("FAIL dot_result: got %0d want 70", result); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL dot_valid: got %0b want 1", result_valid); end
      checks++; if (acc_count !== CNT_W'(4)) begin errors++; $display("FAIL dot_count: got %0d want 4", acc_count); end
      consume();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL dot_consume_valid: got %0b want 0", result_valid); end
      checks++; if (result !== ACC_W'(70)) begin errors++; $display("FAIL dot_consume_keep: got %0d want 70", result); end
   endtask

   task automatic test_signed_step();
      logic [ACC_W-1:0] exp_v;
`ifdef MAC_SIGNED_EN
      exp_v = ACC_W'(-15);
`else
      exp_v = ACC_W'(1265);
`endif
      run_dot({24'd0, 8'hFD}, {24'd0, 8'd5}, 1, 1'b0);
      checks++; if (result !== exp_v) begin errors++; $display("FAIL sign_result: got %0h want %0h", result, exp_v); end
      checks++; if (acc_count !== CNT_W'(1)) begin errors++; $display("FAIL sign_count: got %0d want 1", acc_count); end
      consume();
   endtask

   task automatic test_memsel_boundary();
      a_row = rand_vec() | 32'h0000_0001;
      b_col = rand_vec() | 32'h0000_0001;
      start = 1; cyc(); start = 0;
      memsel = '0;
      load_en = 1; cyc(); load_en = 0;
      mult_en = 1; cyc(); mult_en = 0;
      acc_en = 1; repeat (SIZE + 1) cyc(); acc_en = 0;
      checks++; if (acc_count !== CNT_W'(SIZE)) begin errors++; $display("FAIL count_saturate: got %0d want %0d", acc_count, SIZE); end
      done = 1; cyc(); done = 0;
      checks++; if (result !== '0) begin errors++; $display("FAIL memsel_zero_result: got %0h want 0", result); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL memsel_zero_valid: got %0b want 1", result_valid); end
      consume();
   endtask

   task automatic test_overlap();
      logic [ACC_W-1:0] exp_v;
      a_row = rand_vec(); b_col = rand_vec();
      exp_v = model_dot(a_row, b_col, SIZE);
      start = 1; cyc(); start = 0;
      for (int c = 0; c < SIZE + 2; c++) begin
         load_en = (c < SIZE);
         memsel  = (c < SIZE) ? therm(c) : '0;
         mult_en = (c >= 1 && c <= SIZE);
         acc_en  = (c >= 2);
         cyc();
      end
      load_en = 0; mult_en = 0; acc_en = 0;
      done = 1; cyc(); done = 0;
      checks++; if (result !== exp_v) begin errors++; $display("FAIL overlap_result: got %0h want %0h", result, exp_v); end
      checks++; if (acc_count !== CNT_W'(SIZE)) begin errors++; $display("FAIL overlap_count: got %0d want %0d", acc_count, SIZE); end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [SIZE*WIDTH-1:0] a1, b1, a2, b2;
      logic [ACC_W-1:0] r1;
      a1 = rand_vec(); b1 = rand_vec(); a2 = rand_vec(); b2 = rand_vec();
      r1 = model_dot(a1, b1, SIZE);
      run_dot(a1, b1, SIZE, 1'b0);
      checks++; if (result !== r1) begin errors++; $display("FAIL bp_first_result: got %0h want %0h", result, r1); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL bp_first_ovf: got %0b want 0", ovf_err); end
      run_dot(a2, b2, SIZE, 1'b0);
      checks++; if (result !== r1) begin errors++; $display("FAIL bp_kept_result: got %0h want %0h", result, r1); end
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL bp_ovf_set: got %0b want 1", ovf_err); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b want 1", result_valid); end
      start = 1; cyc(); start = 0;
      done = 1; err_clr = 1; cyc(); done = 0; err_clr = 0;
      checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL bp_set_wins: got %0b want 1", ovf_err); end
      err_clr = 1; cyc(); err_clr = 0;
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL bp_err_clr: got %0b want 0", ovf_err); end
      checks++; if (result !== r1) begin errors++; $display("FAIL bp_final_result: got %0h want %0h", result, r1); end
      consume();
   endtask

   task automatic test_pass_through();
      logic [SIZE*WIDTH-1:0] a1, b1, a2, b2;
      logic [ACC_W-1:0] r2;
      a1 = rand_vec(); b1 = rand_vec(); a2 = rand_vec(); b2 = rand_vec();
      r2 = model_dot(a2, b2, SIZE);
      run_dot(a1, b1, SIZE, 1'b0);
      run_dot(a2, b2, SIZE, 1'b1);
      checks++; if (result !== r2) begin errors++; $display("FAIL pass_result: got %0h want %0h", result, r2); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %0b want 1", result_valid); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL pass_ovf: got %0b want 0", ovf_err); end
      consume();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: got %0b want 0", result_valid); end
   endtask

   task automatic test_reset_mid();
      run_dot(rand_vec(), rand_vec(), SIZE, 1'b0);
      run_dot(rand_vec(), rand_vec(), SIZE, 1'b0);
      a_row = rand_vec() | 32'h0101_0101; b_col = rand_vec() | 32'h0101_0101;
      start = 1; cyc(); start = 0;
      mac_step(0); mac_step(1);
      #2 reset = 0;
      #1;
      checks++; if (result !== '0) begin errors++; $display("FAIL rst_mid_result: got %0h want 0", result); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", result_valid); end
      checks++; if (acc_count !== '0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", acc_count); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %0b want 0", ovf_err); end
      cyc();
      reset = 1;
      mac_step(2);
      done = 1; cyc(); done = 0;
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resume_valid: got %0b want 0", result_valid); end
      checks++; if (acc_count !== '0) begin errors++; $display("FAIL rst_no_resume_count: got %0d want 0", acc_count); end
      run_dot({24'd0, 8'd2}, {24'd0, 8'd3}, 1, 1'b0);
      checks++; if (result !== ACC_W'(6)) begin errors++; $display("FAIL rst_resume_result: got %0d want 6", result); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL rst_resume_valid: got %0b want 1", result_valid); end
      consume();
   endtask

   task automatic test_start_done_collision();
      logic [ACC_W-1:0] s1, s2;
      a_row = rand_vec(); b_col = rand_vec();
      s1 = model_dot(a_row, b_col, SIZE);
      start = 1; cyc(); start = 0;
      for (int k = 0; k < SIZE; k++) mac_step(k);
      start = 1; done = 1; cyc(); start = 0; done = 0;
      checks++; if (result !== s1) begin errors++; $display("FAIL coll_result: got %0h want %0h", result, s1); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %0b want 1", result_valid); end
      checks++; if (acc_count !== '0) begin errors++; $display("FAIL coll_count: got %0d want 0", acc_count); end
      a_row = rand_vec() | 32'h0000_0001; b_col = rand_vec() | 32'h0000_0001;
      s2 = model_dot(a_row, b_col, 1);
      mac_step(0);
      done = 1; result_ready = 1; cyc(); done = 0; result_ready = 0;
      checks++; if (result !== s2) begin errors++; $display("FAIL coll_fresh_sum: got %0h want %0h", result, s2); end
      checks++; if (acc_count !== CNT_W'(1)) begin errors++; $display("FAIL coll_fresh_count: got %0d want 1", acc_count); end
      consume();
   endtask

   task automatic test_random();
      logic [SIZE*WIDTH-1:0] a, b;
      logic [ACC_W-1:0] exp_result;
      logic exp_valid, exp_ovf, rdy, rr, ec;
      int n;
      exp_valid = 0; exp_ovf = 0; exp_result = result;
      for (int it = 0; it < 24; it++) begin
         a = rand_vec(); b = rand_vec();
         n = int'($urandom_range(1, SIZE));
         rdy = 1'($urandom_range(0, 1));
         run_dot(a, b, n, rdy);
         if (!exp_valid || rdy) begin
            exp_result = model_dot(a, b, n);
            exp_valid = 1;
         end else begin
            exp_ovf = 1;
         end
         checks++; if (result !== exp_result) begin errors++; $display("FAIL rand_result[%0d]: got %0h want %0h", it, result, exp_result); end
         checks++; if (result_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0b want %0b", it, result_valid, exp_valid); end
         checks++; if (ovf_err !== exp_ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %0b want %0b", it, ovf_err, exp_ovf); end
         checks++; if (acc_count !== CNT_W'(n)) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, acc_count, n); end
         rr = 1'($urandom_range(0, 1));
         ec = ($urandom_range(0, 3) == 0);
         result_ready = rr; err_clr = ec; cyc(); result_ready = 0; err_clr = 0;
         if (rr) exp_valid = 0;
         if (ec) exp_ovf = 0;
         checks++; if (result_valid !== exp_valid) begin errors++; $display("FAIL rand_drain_valid[%0d]: got %0b want %0b", it, result_valid, exp_valid); end
         checks++; if (ovf_err !== exp_ovf) begin errors++; $display("FAIL rand_drain_ovf[%0d]: got %0b want %0b", it, ovf_err, exp_ovf); end
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_unsigned_dot();
      test_signed_step();
      test_memsel_boundary();
      test_overlap();
      test_back_to_back();
      test_pass_through();
      test_reset_mid();
      test_start_done_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
